// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - frame shift register with selectable bit order
// The first bit received ends up at the MSB or LSB once the frame is full.
module sipo_shift_core #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - serial-to-parallel frame receiver with valid/ready output
// A frame is WIDTH accepted bits; completed words queue one deep and overflow flags overrun.
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     din,
  input  logic                     din_valid,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic             fc;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (din_valid),
    .din   (din),
    .q     (shreg)
  );

  // The final bit is not in shreg yet at the completing edge, so merge it here.
  assign next_word = MSB_FIRST ? {shreg[WIDTH-2:0], din} : {din, shreg[WIDTH-1:1]};
  assign fc        = din_valid && (bit_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clr) begin
      bit_cnt    <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (din_valid) begin
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      end
      if (fc) begin
        if (!pout_valid || pout_ready) begin
          pout       <= next_word;
          pout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
    end
  end

endmodule
